// File: rtl/block_code_pkg.sv
// Shared definitions for the block-code bit packer: default word width, tuser
// width helper and the packer FSM state type.
package block_code_pkg;

  localparam int unsigned BCP_OUT_WIDTH_DEFAULT = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } packer_state_t;

  // tuser carries a count of 1..OUT_WIDTH valid bits
  function automatic int unsigned tuser_w(input int unsigned out_width);
    return $clog2(out_width + 1);
  endfunction

endpackage

// File: rtl/bcp_out_reg.sv
// One-entry AXI4-Stream output register: load captures a new word, pop clears
// the entry unless a new word loads in the same cycle.
module bcp_out_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned USER_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              pop,
  input  logic [DATA_W-1:0] load_data,
  input  logic [USER_W-1:0] load_user,
  input  logic              load_last,
  output logic [DATA_W-1:0] tdata,
  output logic [USER_W-1:0] tuser,
  output logic              tlast,
  output logic              tvalid
);

  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [USER_W-1:0] tuser_q, tuser_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;

  always_comb begin
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (load) begin
      tdata_d  = load_data;
      tuser_d  = load_user;
      tlast_d  = load_last;
      tvalid_d = 1'b1;
    end else if (pop) begin
      tdata_d  = '0;
      tuser_d  = '0;
      tlast_d  = 1'b0;
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign tdata  = tdata_q;
  assign tuser  = tuser_q;
  assign tlast  = tlast_q;
  assign tvalid = tvalid_q;

endmodule

// File: rtl/block_code_bit_packer.sv
// Packs a serial 1-bit AXI4-Stream into OUT_WIDTH-bit words, first bit in MSB.
// Optional frame length check enabled by defining BLOCK_CODE_PACKER_LEN_CHECK_EN.
module block_code_bit_packer
  import block_code_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = BCP_OUT_WIDTH_DEFAULT,
  parameter int unsigned LEN_W     = 8
) (
  input  logic                               clk,
  input  logic                               s_axis_aresetn,
  input  logic [LEN_W-1:0]                   code_length,
  input  logic                               code_length_valid,
  input  logic                               s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic                               s_axis_tlast,
  output logic [OUT_WIDTH-1:0]               m_axis_tdata,
  output logic [tuser_w(OUT_WIDTH)-1:0]      m_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic                               len_err
);

  localparam int unsigned CNT_W   = $clog2(OUT_WIDTH);
  localparam int unsigned TUSER_W = tuser_w(OUT_WIDTH);

  packer_state_t         state_q, state_d;
  logic [OUT_WIDTH-2:0]  acc_q, acc_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

  logic                  accept;
  logic                  word_done;
  logic                  out_pop;
  logic [OUT_WIDTH-1:0]  shifted;
  logic [OUT_WIDTH-1:0]  word_aligned;
  logic [TUSER_W-1:0]    word_user;

  assign s_axis_tready = (state_q == ACCUM) || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign word_done     = accept && ((bit_cnt_q == CNT_W'(OUT_WIDTH - 1)) || s_axis_tlast);
  assign out_pop       = m_axis_tvalid && m_axis_tready;

  // Only the newest bit_cnt+1 bits belong to this word; the left shift drops
  // stale history off the top and zero-fills the unused LSBs.
  assign shifted      = {acc_q, s_axis_tdata};
  assign word_aligned = shifted << (CNT_W'(OUT_WIDTH - 1) - bit_cnt_q);
  assign word_user    = TUSER_W'(bit_cnt_q) + TUSER_W'(1);

  always_comb begin
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    state_d   = state_q;
    if (accept) begin
      acc_d     = shifted[OUT_WIDTH-2:0];
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
    end
    if (word_done) begin
      state_d = EMIT;
    end else if (out_pop) begin
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  bcp_out_reg #(
    .DATA_W (OUT_WIDTH),
    .USER_W (TUSER_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (s_axis_aresetn),
    .load      (word_done),
    .pop       (out_pop),
    .load_data (word_aligned),
    .load_user (word_user),
    .load_last (s_axis_tlast),
    .tdata     (m_axis_tdata),
    .tuser     (m_axis_tuser),
    .tlast     (m_axis_tlast),
    .tvalid    (m_axis_tvalid)
  );

`ifdef BLOCK_CODE_PACKER_LEN_CHECK_EN
  logic [LEN_W-1:0] code_len_q, code_len_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [LEN_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             len_err_q, len_err_d;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W:0]   cnt_next;

  // The first beat of a frame snapshots code_len_q, so a mid-frame update of
  // code_length only applies from the following frame.
  assign cur_len  = (frame_cnt_q == '0) ? code_len_q : frame_len_q;
  assign cnt_next = {1'b0, frame_cnt_q} + {{LEN_W{1'b0}}, 1'b1};

  always_comb begin
    code_len_d  = code_length_valid ? code_length : code_len_q;
    frame_len_d = frame_len_q;
    frame_cnt_d = frame_cnt_q;
    len_err_d   = 1'b0;
    if (accept) begin
      frame_len_d = cur_len;
      if (s_axis_tlast) begin
        frame_cnt_d = '0;
        len_err_d   = (cnt_next != {1'b0, cur_len});
      end else begin
        if (frame_cnt_q != '1) begin
          frame_cnt_d = cnt_next[LEN_W-1:0];
        end
        len_err_d = (cnt_next == {1'b0, cur_len});
      end
    end
  end

  always_ff @(posedge clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      code_len_q  <= '0;
      frame_len_q <= '0;
      frame_cnt_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      code_len_q  <= code_len_d;
      frame_len_q <= frame_len_d;
      frame_cnt_q <= frame_cnt_d;
      len_err_q   <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  logic unused_len_inputs;
  assign unused_len_inputs = ^{code_length, code_length_valid};
  assign len_err           = 1'b0;
`endif

endmodule

// File: tb/tb_block_code_bit_packer.sv
// Randomized and directed bench for block_code_bit_packer with a frame-level
// reference model (word list and expected len_err pulse count per frame).
module tb_block_code_bit_packer;

  localparam int OW = 8;
  localparam int LW = 8;
  localparam int UW = $clog2(OW + 1);
`ifdef BLOCK_CODE_PACKER_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] code_length = '0;
  logic          code_length_valid = 1'b0;
  logic          s_axis_tdata = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [OW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          len_err;

  block_code_bit_packer #(
    .OUT_WIDTH (OW),
    .LEN_W     (LW)
  ) dut (
    .clk               (clk),
    .s_axis_aresetn    (rst_n),
    .code_length       (code_length),
    .code_length_valid (code_length_valid),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .len_err           (len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [OW-1:0] d;
    int            u;
    bit            l;
  } word_t;

  word_t exp_q[$];
  bit    frame_bits[256];
  int    model_len = 0;
  int    err_exp = 0;
  int    err_seen = 0;
  int    stalls = 0;
  int    rdy_mode = 0;
  int    cyc = 0;

  // Downstream ready pattern generator
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ((cyc % 30) >= 20);
      2:       m_axis_tready = (($urandom % 3) != 0);
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Output monitor / scoreboard
  word_t         mw;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (len_err) err_seen++;
      if (prev_stall) begin
        check_eq("hold_tvalid", 32'(m_axis_tvalid), 1);
        check_eq("hold_tdata", 32'(m_axis_tdata), 32'(prev_d));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", exp_q.size(), 1);
        end else begin
          mw = exp_q.pop_front();
          check_eq("tdata", 32'(m_axis_tdata), 32'(mw.d));
          check_eq("tuser", 32'(m_axis_tuser), mw.u);
          check_eq("tlast", 32'(m_axis_tlast), 32'(mw.l));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
    end
  end

  task automatic send_beat(input bit b, input bit last);
    bit ok = 1'b0;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = s_axis_tready;
      if (!ok) stalls++;
    end
    if (!ok) check_eq("beat_accept_timeout", 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  // Sends frame_bits[0..n-1]; upd reprograms code_length on the second beat so
  // the new value governs the following frame.
  task automatic send_frame(input int n, input bit term, input bit upd, input int next_len);
    int L = model_len;
    if (term) begin
      for (int w0 = 0; w0 < n; w0 += OW) begin
        word_t e;
        int    cnt;
        cnt = (n - w0 < OW) ? (n - w0) : OW;
        e.d = '0;
        for (int j = 0; j < cnt; j++) e.d[OW-1-j] = frame_bits[w0+j];
        e.u = cnt;
        e.l = (w0 + cnt == n);
        exp_q.push_back(e);
      end
      if (LEN_CHK) err_exp += int'(n != L) + int'(L >= 1 && L < n);
    end else if (LEN_CHK) begin
      err_exp += int'(L >= 1 && L <= n);
    end
    for (int i = 0; i < n; i++) begin
      if (i == 1 && upd) begin
        code_length       = LW'(next_len);
        code_length_valid = 1'b1;
      end
      send_beat(frame_bits[i], term && (i == n - 1));
      if (i == 1 && upd) begin
        code_length_valid = 1'b0;
        model_len         = next_len;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic set_len(input int v);
    code_length       = LW'(v);
    code_length_valid = 1'b1;
    @(posedge clk);
    #1;
    code_length_valid = 1'b0;
    model_len         = v;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_drain"}, exp_q.size(), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_len_err_count"}, err_seen, err_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v16;
    logic [4:0]  v5;
    real         t0;
    int          n;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_tvalid", 32'(m_axis_tvalid), 0);
    check_eq("reset_tdata", 32'(m_axis_tdata), 0);
    check_eq("reset_tuser", 32'(m_axis_tuser), 0);
    check_eq("reset_len_err", 32'(len_err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: five-bit frame matching code_length
    set_len(5);
    v5 = 5'b10110;
    for (int i = 0; i < 5; i++) frame_bits[i] = v5[4-i];
    send_frame(5, 1'b1, 1'b0, 0);
    drain("t1");

    // 2: two full words, tlast on the 16th bit
    set_len(16);
    v16 = 16'hA53C;
    for (int i = 0; i < 16; i++) frame_bits[i] = v16[15-i];
    send_frame(16, 1'b1, 1'b0, 0);
    drain("t2");

    // 3: same frame under 20-low/10-high back-pressure
    rdy_mode = 1;
    stalls = 0;
    send_frame(16, 1'b1, 1'b0, 0);
    drain("t3");
    rdy_mode = 0;

    // 4: short frame, then an over-long unterminated frame
    set_len(6);
    for (int i = 0; i < 4; i++) frame_bits[i] = 1'($urandom);
    send_frame(4, 1'b1, 1'b0, 0);
    drain("t4a");
    for (int i = 0; i < 7; i++) frame_bits[i] = 1'($urandom);
    send_frame(7, 1'b0, 1'b0, 0);
    drain("t4b");

    // 5: complete a word while held, then reset mid-frame
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send_beat(1'b1, 1'b0);
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_pre_reset_tvalid", 32'(m_axis_tvalid), 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_tvalid", 32'(m_axis_tvalid), 0);
    check_eq("t5_rst_tdata", 32'(m_axis_tdata), 0);
    check_eq("t5_rst_tuser", 32'(m_axis_tuser), 0);
    check_eq("t5_rst_tlast", 32'(m_axis_tlast), 0);
    check_eq("t5_rst_len_err", 32'(len_err), 0);
    model_len = 0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_bits[0] = 1'b1;
    frame_bits[1] = 1'b1;
    send_frame(2, 1'b1, 1'b0, 0);
    drain("t5");

    // 6: back-to-back frames of length 2..7 with matching code_length
    set_len(2);
    stalls = 0;
    t0 = $realtime;
    for (int k = 2; k <= 7; k++) begin
      for (int i = 0; i < k; i++) frame_bits[i] = 1'($urandom);
      send_frame(k, 1'b1, 1'b1, k + 1);
    end
    check_eq("t6_sweep_cycles", 32'(int'(($realtime - t0) / 10.0)), 27);
    check_eq("t6_stalls", stalls, 0);
    drain("t6");

    // 7: random frames, random lengths, random back-pressure and gaps
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) frame_bits[i] = 1'($urandom);
      send_frame(n, 1'b1, (n >= 2) && ($urandom % 2 == 1), $urandom_range(1, 30));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain("t7");
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
